stepper_scheduler: RTL and testbench
====================================

STEPPER_SCHEDULER -- requirements
Module: stepper_scheduler

Interface
REQ-001 SHALL have parameter fixedPointBaseBits, default 16: width of delta_steps, in step/16 (microstep) units.
REQ-002 SHALL have parameter pendingBits, default 20: signed width of the internal pending-microstep accumulator.
REQ-003 SHALL have parameter pulseHigh, default 250: step high time in clock cycles, range 1..65535.
REQ-004 SHALL have parameter pulseLow, default 250: minimum step low time in clock cycles, range 1..65535.
REQ-005 SHALL have parameter dirSetup, default 500: cycles dir is held stable before a step after a direction change, range 1..65535.
REQ-006 SHALL have ports: clock  in  1  system clock, all logic on its rising edge.
REQ-007 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: enable  in  1  1 = accept ticks and emit pulses.
REQ-009 SHALL have ports: sim_clock  in  1  simulator tick clock, generated in the clock domain; the rising edge is the tick.
REQ-010 SHALL have ports: delta_steps  in  fixedPointBaseBits  signed microsteps to add this tick.
REQ-011 SHALL have ports: step  out  1  registered step pulse, one pulse = one microstep.
REQ-012 SHALL have ports: dir  out  1  registered direction, 1 = positive.
REQ-013 SHALL have ports: busy  out  1  1 when FSM not IDLE or pending != 0.
REQ-014 SHALL have ports: overrun  out  1  sticky accumulator-saturation flag.
REQ-015 SHALL have ports: pending  out  pendingBits  signed microsteps not yet issued.

Function
REQ-016 SHALL register sim_clock once; tick = sim_clock & ~sim_clock_q, one clock wide; no further synchroniser.
REQ-017 On tick with enable=1, pending SHALL become sat(pending + sext(delta_steps) - commit) at the end of that cycle; commit is the +/-1 consumed the same cycle (REQ-021), and sat() clamps to +/-(2^(pendingBits-1)-1).
REQ-018 Any clamp by sat() SHALL set overrun; overrun SHALL clear only on reset.
REQ-019 FSM states SHALL be IDLE, DIR_SETUP, STEP_HIGH and STEP_LOW, sharing one 16-bit down-counter.
REQ-020 IDLE SHALL go to DIR_SETUP when enable=1, pending != 0 and sign(pending) differs from dir; in that transition dir toggles and the counter loads dirSetup-1.
REQ-021 IDLE or DIR_SETUP (counter=0) SHALL go to STEP_HIGH when enable=1, pending != 0 and sign matches dir; that transition is the commit: pending moves 1 toward zero, and the counter loads pulseHigh-1.
REQ-022 STEP_HIGH SHALL hold step=1; at counter=0 it goes to STEP_LOW, loading pulseLow-1.
REQ-023 STEP_LOW SHALL hold step=0; at counter=0 it goes to IDLE.
REQ-024 A pulse once started SHALL always complete both STEP_HIGH and STEP_LOW; dir SHALL NOT change outside the IDLE->DIR_SETUP transition.
REQ-025 If pending is 0 or enable=0 when DIR_SETUP expires, the FSM SHALL go to IDLE without a step.
REQ-026 While enable=0, pending SHALL be forced to 0, ticks SHALL be discarded, no new pulse SHALL start, and any in-flight pulse SHALL finish.
REQ-027 Latency SHALL be: tick sampled in cycle N, no direction change -> step=1 from cycle N+2 onward.
REQ-028 If a tick flips the sign of pending during a pulse, the FSM SHALL finish the pulse, then take DIR_SETUP.
REQ-029 The sustained step rate SHALL be one microstep per pulseHigh+pulseLow+1 cycles.

Reset
REQ-030 While reset_n=0, step SHALL be 0, dir 1, busy 0, overrun 0, pending 0, FSM IDLE, counter 0 and sim_clock_q 0, asynchronously.
REQ-031 Reset asserted mid-pulse SHALL drop step in the same instant without waiting for a clock.

Verification (bench parameters: pulseHigh=4, pulseLow=4, dirSetup=8)
REQ-032 Reset check: reset_n=0 with sim_clock toggling and delta_steps=5 -> step=0, dir=1, pending=0, busy=0, overrun=0 throughout.
REQ-033 Positive run: enable=1, one tick with delta_steps=+3 -> dir stays 1; step rises at N+2; three pulses, each 4 high/5 low; pending reads 3,2,1,0; busy falls after the last STEP_LOW.
REQ-034 Reversal: from idle dir=1, tick with delta_steps=-2 -> dir=0 one cycle after IDLE; 8 cycles later the first step; two pulses; pending -2 -> 0.
REQ-035 Simultaneous: pending=+1 and a tick with +5 in the cycle of a commit -> pending=+5 next cycle, not +6.
REQ-036 Saturation: pending=524280, tick with +100 -> pending=524287, overrun=1, and it stays 1 after pending drains to 0.
REQ-037 Disruption: enable drops during STEP_HIGH -> the pulse completes 4/5, pending=0, no further steps, ticks ignored. Reset_n pulsed low during STEP_HIGH -> step=0 immediately, all reset values.

Source files
------------

// File: rtl/stepper_scheduler.sv
// stepper_scheduler: turns per-tick signed microstep deltas into step/dir
// pulses. A saturating accumulator holds the microsteps not yet issued; a
// four-state sequencer drains it one microstep per pulse, inserting a
// direction setup interval whenever the sign of the backlog changes.
module stepper_scheduler #(
    parameter int fixedPointBaseBits = 16,
    parameter int pendingBits        = 20,
    parameter int pulseHigh          = 250,
    parameter int pulseLow           = 250,
    parameter int dirSetup           = 500
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic                                 sim_clock,
    input  logic signed [fixedPointBaseBits-1:0] delta_steps,
    output logic                                 step,
    output logic                                 dir,
    output logic                                 busy,
    output logic                                 overrun,
    output logic signed [pendingBits-1:0]        pending,
    output logic [1:0]                           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        STEP_HIGH = 2'd2,
        STEP_LOW  = 2'd3
    } state_t;

    // Arithmetic width: wide enough that pending + delta - 1 never wraps.
    localparam int AW = ((pendingBits > fixedPointBaseBits) ? pendingBits : fixedPointBaseBits) + 2;

    localparam logic signed [AW-1:0] PMAX = {{(AW-pendingBits+1){1'b0}}, {(pendingBits-1){1'b1}}};
    localparam logic signed [AW-1:0] PMIN = -PMAX;
    localparam logic signed [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

    localparam logic [15:0] HIGH_LOAD  = 16'(pulseHigh - 1);
    localparam logic [15:0] LOW_LOAD   = 16'(pulseLow - 1);
    localparam logic [15:0] SETUP_LOAD = 16'(dirSetup - 1);

    state_t                         state_q;
    logic [15:0]                    cnt_q;
    logic                           step_q;
    logic                           dir_q;
    logic                           sim_clock_q;
    logic                           overrun_q;
    logic                           overrun_d;
    logic signed [pendingBits-1:0]  pending_q;
    logic signed [pendingBits-1:0]  pending_d;

    logic                           tick;
    logic                           have_work;
    logic                           sign_match;
    logic                           commit;
    logic                           need_flip;
    logic signed [AW-1:0]           sum;
    logic signed [AW-1:0]           delta_ext;
    logic                           clamp;

    assign tick = sim_clock & ~sim_clock_q;

    // Decide whether this cycle consumes a microstep or needs a direction change.
    always_comb begin
        have_work  = enable && (pending_q != '0);
        sign_match = (~pending_q[pendingBits-1]) == dir_q;
        commit     = have_work && sign_match &&
                     ((state_q == IDLE) || ((state_q == DIR_SETUP) && (cnt_q == 16'd0)));
        need_flip  = have_work && !sign_match && (state_q == IDLE);
    end

    // Next backlog: add the tick's delta, remove the committed microstep, saturate.
    always_comb begin
        delta_ext = {{(AW-fixedPointBaseBits){delta_steps[fixedPointBaseBits-1]}}, delta_steps};
        sum       = {{(AW-pendingBits){pending_q[pendingBits-1]}}, pending_q};
        if (tick && enable) begin
            sum = sum + delta_ext;
        end
        if (commit) begin
            sum = dir_q ? (sum - ONE) : (sum + ONE);
        end
        pending_d = sum[pendingBits-1:0];
        clamp     = 1'b0;
        if (sum > PMAX) begin
            pending_d = PMAX[pendingBits-1:0];
            clamp     = 1'b1;
        end else if (sum < PMIN) begin
            pending_d = PMIN[pendingBits-1:0];
            clamp     = 1'b1;
        end
        if (!enable) begin
            pending_d = '0;
        end
        overrun_d = overrun_q | (clamp & enable);
    end

    // Tick edge register, backlog accumulator and sticky saturation flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sim_clock_q <= 1'b0;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            sim_clock_q <= sim_clock;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    // Pulse sequencer: one shared down-counter times setup, high and low phases.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (commit) begin
                        state_q <= STEP_HIGH;
                        cnt_q   <= HIGH_LOAD;
                        step_q  <= 1'b1;
                    end else if (need_flip) begin
                        state_q <= DIR_SETUP;
                        cnt_q   <= SETUP_LOAD;
                        dir_q   <= ~dir_q;
                    end
                end
                DIR_SETUP: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (commit) begin
                        state_q <= STEP_HIGH;
                        cnt_q   <= HIGH_LOAD;
                        step_q  <= 1'b1;
                    end else begin
                        // Backlog vanished or sequencer disabled during setup.
                        state_q <= IDLE;
                    end
                end
                STEP_HIGH: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        state_q <= STEP_LOW;
                        cnt_q   <= LOW_LOAD;
                        step_q  <= 1'b0;
                    end
                end
                STEP_LOW: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    step_q  <= 1'b0;
                end
            endcase
        end
    end

    assign step        = step_q;
    assign dir         = dir_q;
    assign busy        = (state_q != IDLE) || (pending_q != '0);
    assign overrun     = overrun_q;
    assign pending     = pending_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stepper_scheduler.sv
// Bench for stepper_scheduler: a time-stamped reference model predicts
// step/dir/pending/busy/overrun every cycle; directed scenarios add
// explicit constant checks for latency, reversal, saturation and disruption.
module tb_stepper_scheduler;

    localparam int PH   = 4;
    localparam int PL   = 4;
    localparam int DS   = 8;
    localparam int MAXP = 524287;

    // ---------------- clock / reset ----------------
    logic               clock = 1'b0;
    logic               reset_n;
    logic               enable;
    logic               sim_clock;
    logic signed [15:0] delta_steps;
    logic               step;
    logic               dir;
    logic               busy;
    logic               overrun;
    logic signed [19:0] pending;
    logic [1:0]         dbg_state;

    always #5 clock = ~clock;

    stepper_scheduler #(
        .fixedPointBaseBits(16),
        .pendingBits       (20),
        .pulseHigh         (PH),
        .pulseLow          (PL),
        .dirSetup          (DS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .sim_clock  (sim_clock),
        .delta_steps(delta_steps),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .overrun    (overrun),
        .pending    (pending),
        .dbg_state_o(dbg_state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-stamped view: a commit at cycle c makes step high in c+1..c+PH and
    // allows the next decision at c+PH+PL+1; a direction flip at cycle c
    // allows the next decision at c+DS (the final setup cycle).
    int m_t;
    int m_pend;
    bit m_dir;
    bit m_ovr;
    bit m_prev_sc;
    int m_decide_at;
    int m_setup_end;
    int m_last_commit;

    function automatic bit m_step_now();
        return (m_t >= m_last_commit + 1) && (m_t <= m_last_commit + PH);
    endfunction

    function automatic bit m_busy_now();
        return (m_t < m_decide_at) || (m_t == m_setup_end) || (m_pend != 0);
    endfunction

    task automatic model_reset();
        m_pend        = 0;
        m_dir         = 1'b1;
        m_ovr         = 1'b0;
        m_prev_sc     = 1'b0;
        m_decide_at   = m_t;
        m_setup_end   = m_t - 1;
        m_last_commit = m_t - 100;
    endtask

    task automatic model_step(input bit en, input bit sc, input int delta);
        bit     tk;
        bit     can;
        bit     setup_pt;
        bit     match;
        bit     commit;
        bit     flip;
        longint s;
        tk       = sc && !m_prev_sc;
        can      = (m_t >= m_decide_at);
        setup_pt = (m_t == m_setup_end);
        match    = en && (m_pend != 0) && ((m_pend > 0) == m_dir);
        commit   = can && match;
        flip     = can && !setup_pt && en && (m_pend != 0) && !match;
        s = m_pend;
        if (tk && en) s = s + delta;
        if (commit) s = m_dir ? s - 1 : s + 1;
        if (s > MAXP) begin
            s = MAXP;
            m_ovr = 1'b1;
        end else if (s < -MAXP) begin
            s = -MAXP;
            m_ovr = 1'b1;
        end
        if (!en) s = 0;
        if (commit) begin
            m_last_commit = m_t;
            m_decide_at   = m_t + PH + PL + 1;
        end
        if (flip) begin
            m_dir       = !m_dir;
            m_decide_at = m_t + DS;
            m_setup_end = m_t + DS;
        end
        m_pend    = int'(s);
        m_prev_sc = sc;
        m_t++;
    endtask

    // ---------------- scoreboard for the directed pending sequence ----------------
    logic [19:0] exp_q[$];
    bit          sb_on     = 1'b0;
    logic [19:0] last_pend = '0;
    bit          last_step = 1'b0;
    int          rises     = 0;
    bit          en_cur    = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit en, input bit sc, input int delta);
        @(negedge clock);
        check("step",    step,    m_step_now());
        check("dir",     dir,     m_dir);
        check("pending", pending, m_pend);
        check("busy",    busy,    m_busy_now());
        check("overrun", overrun, m_ovr);
        if (sb_on && (pending != last_pend)) begin
            if (exp_q.size() == 0) check("sb_extra_change", pending, last_pend);
            else check("sb_pending_seq", pending, $signed(exp_q.pop_front()));
        end
        last_pend = pending;
        if (step && !last_step) rises++;
        last_step = step;
        enable      = en;
        sim_clock   = sc;
        delta_steps = 16'(delta);
        model_step(en, sc, delta);
    endtask

    task automatic do_tick(input int delta);
        cycle(en_cur, 1'b1, delta);
        cycle(en_cur, 1'b0, 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(en_cur, 1'b0, 0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        enable      = 1'b0;
        sim_clock   = 1'b0;
        delta_steps = '0;
        reset_n     = 1'b1;
        model_reset();
        model_step(1'b0, 1'b0, 0);
        last_step = 1'b0;
        last_pend = '0;
    endtask

    task automatic wait_step_high();
        for (int k = 0; k < 40 && !m_step_now(); k++) cycle(en_cur, 1'b0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mark;
        m_t         = 0;
        reset_n     = 1'b0;
        enable      = 1'b1;
        sim_clock   = 1'b0;
        delta_steps = 16'sd5;
        model_reset();

        // Reset held with ticks arriving: everything stays at reset values.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("rst_step", step, 0);
            check("rst_dir", dir, 1);
            check("rst_pending", pending, 0);
            check("rst_busy", busy, 0);
            check("rst_overrun", overrun, 0);
            sim_clock = ~sim_clock;
        end
        release_reset();
        en_cur = 1'b1;
        run(3);

        // Positive run of three microsteps.
        exp_q = {20'd3, 20'd2, 20'd1, 20'd0};
        sb_on = 1'b1;
        mark  = rises;
        do_tick(3);
        cycle(en_cur, 1'b0, 0);
        check("latency_step_n2", step, 1);
        check("pos_dir", dir, 1);
        run(40);
        sb_on = 1'b0;
        check("pos_sb_drained", exp_q.size(), 0);
        check("pos_pulses", rises - mark, 3);
        check("pos_busy_end", busy, 0);

        // Reversal from idle with dir=1.
        mark = rises;
        do_tick(-2);
        cycle(en_cur, 1'b0, 0);
        check("rev_dir_flipped", dir, 0);
        run(7);
        check("rev_setup_no_step", step, 0);
        cycle(en_cur, 1'b0, 0);
        check("rev_first_step", step, 1);
        run(40);
        check("rev_pulses", rises - mark, 2);
        check("rev_pending_end", pending, 0);

        // Return to dir=1, then tick landing exactly on a commit cycle.
        do_tick(1);
        run(40);
        do_tick(2);
        run(8);
        cycle(en_cur, 1'b1, 5);
        check("sim_pending_before", pending, 1);
        cycle(en_cur, 1'b0, 0);
        check("sim_pending_after", pending, 5);
        run(80);

        // Saturation: ramp close to the limit, settle at 524280, add 100.
        for (int k = 0; k < 40 && (m_pend + 32767 <= 524283); k++) do_tick(32767);
        do_tick(524283 - m_pend);
        for (int k = 0; k < 200 && m_pend != 524280; k++) cycle(en_cur, 1'b0, 0);
        cycle(en_cur, 1'b1, 100);
        check("sat_pending_pre", pending, 524280);
        check("sat_overrun_pre", overrun, 0);
        cycle(en_cur, 1'b0, 0);
        check("sat_pending_clamped", pending, MAXP);
        check("sat_overrun_set", overrun, 1);

        // Enable dropped during STEP_HIGH: pulse completes, backlog cleared.
        wait_step_high();
        cycle(1'b0, 1'b0, 0);
        check("dis_in_high", step, 1);
        en_cur = 1'b0;
        mark   = rises;
        run(4);
        do_tick(9);
        run(4);
        do_tick(-9);
        run(10);
        check("dis_no_new_pulse", rises - mark, 0);
        check("dis_pending_zero", pending, 0);
        check("dis_overrun_sticky", overrun, 1);
        check("dis_busy", busy, 0);
        check("dis_step", step, 0);

        // Reset pulsed mid STEP_HIGH: step drops without a clock edge.
        en_cur = 1'b1;
        run(2);
        do_tick(3);
        wait_step_high();
        cycle(en_cur, 1'b0, 0);
        check("pre_rst_step", step, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_step", step, 0);
        check("async_rst_dir", dir, 1);
        check("async_rst_pending", pending, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overrun", overrun, 0);
        release_reset();

        // Randomized traffic against the model.
        en_cur = 1'b1;
        begin
            bit sc_cur;
            sc_cur = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                int d;
                d = int'($urandom_range(0, 12)) - 6;
                if (sc_cur) sc_cur = 1'b0;
                else sc_cur = ($urandom_range(0, 4) == 0);
                if (en_cur && $urandom_range(0, 199) == 0) en_cur = 1'b0;
                else if (!en_cur && $urandom_range(0, 19) == 0) en_cur = 1'b1;
                cycle(en_cur, sc_cur, d);
            end
        end
        en_cur = 1'b1;
        run(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
